// File: rtl/iq_cordic_if.sv
// iq_cordic_if: analytic-sample input and polar-result output bundle for iq_cordic
interface iq_cordic_if;
    logic               in_valid;
    logic signed [12:0] Re;
    logic signed [12:0] Im;
    logic               busy;
    logic [13:0]        mag;
    logic [15:0]        phase;
    logic               out_valid;
    logic               overrun;
    modport master(output in_valid, Re, Im, input busy, mag, phase, out_valid, overrun);
    modport slave(input in_valid, Re, Im, output busy, mag, phase, out_valid, overrun);
endinterface

// File: rtl/iq_cordic.sv
// iq_cordic: iterative vectoring CORDIC turning (Re, Im) into uncompensated magnitude and phase
module iq_cordic #(
    parameter int ITER = 12
) (
    input logic        clock,
    input logic        reset,
    iq_cordic_if.slave s
);
    typedef enum logic {IDLE, ROT} state_t;
    localparam logic [15:0] ATAN [12] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326,
                                          16'd163, 16'd81, 16'd41, 16'd20, 16'd10, 16'd5};
    state_t             state, state_n;
    logic [3:0]         i;
    logic signed [15:0] x, y, xs, ys, xn, yn, re_x, im_x;
    logic [15:0]        z, zn;
    logic               zero, accept, last;
    assign re_x   = {{3{s.Re[12]}}, s.Re};
    assign im_x   = {{3{s.Im[12]}}, s.Im};
    assign accept = state == IDLE && s.in_valid;
    assign last   = state == ROT && i == 4'(ITER - 1);
    assign xs     = x >>> i;
    assign ys     = y >>> i;
    assign xn     = y[15] ? x - ys : x + ys;
    assign yn     = y[15] ? y + xs : y - xs;
    assign zn     = y[15] ? z - ATAN[i] : z + ATAN[i];
    assign s.busy = state == ROT;
    always_comb begin
        state_n = state;
        if (accept) state_n = ROT;
        else if (last) state_n = IDLE;
    end
    always_ff @(posedge clock) state <= !reset ? IDLE : state_n;
    // Left-half inputs are pre-rotated by pi so the iterations only need to cover +-pi/2
    always_ff @(posedge clock) begin
        if (!reset) begin
            s.mag       <= '0;
            s.phase     <= '0;
            s.out_valid <= 1'b0;
            s.overrun   <= 1'b0;
        end else begin
            s.out_valid <= last;
            if (state == ROT && s.in_valid) s.overrun <= 1'b1;
            if (accept) begin
                x    <= s.Re[12] ? -re_x : re_x;
                y    <= s.Re[12] ? -im_x : im_x;
                z    <= {s.Re[12], 15'd0};
                i    <= '0;
                zero <= s.Re == '0 && s.Im == '0;
            end else if (state == ROT) begin
                x <= xn;
                y <= yn;
                z <= zn;
                i <= last ? i : i + 4'd1;
            end
            if (last) begin
                s.mag   <= zero ? '0 : xn[13:0];
                s.phase <= zero ? '0 : zn;
            end
        end
    end
endmodule
